// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types and the EX/MEM trap FSM state encoding
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0] regbits_t;
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;
    typedef enum logic {IDLE, TRAP} trapstate_t;
endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if: EX->MEM stage bundle; latch modport is the pipeline register, tb drives EX/control and observes MEM
interface ex_mem_if;
    import cpu_types_pkg::*;
    word_t outputPort, ex_pc, ex_storedata, ex_btarget;
    logic negative, overflow, zero, ex_valid;
    regbits_t ex_wsel;
    logic ex_regwen, ex_memren, ex_memwen, ex_beq, ex_bne, ex_ovfchk;
    logic mem_stall, flush, exc_ack, ex_ready;
    logic mem_valid, mem_regwen, mem_memren, mem_memwen, branch_taken;
    word_t mem_result, mem_storedata, mem_btarget, epc;
    regbits_t mem_wsel;
    logic exc_req;
    logic [7:0] ovf_count;
    modport latch (
        input outputPort, negative, overflow, zero, ex_valid, ex_pc, ex_storedata, ex_btarget,
              ex_wsel, ex_regwen, ex_memren, ex_memwen, ex_beq, ex_bne, ex_ovfchk,
              mem_stall, flush, exc_ack,
        output ex_ready, mem_valid, mem_regwen, mem_memren, mem_memwen, branch_taken,
               mem_result, mem_storedata, mem_btarget, epc, mem_wsel, exc_req, ovf_count
    );
    modport tb (
        output outputPort, negative, overflow, zero, ex_valid, ex_pc, ex_storedata, ex_btarget,
               ex_wsel, ex_regwen, ex_memren, ex_memwen, ex_beq, ex_bne, ex_ovfchk,
               mem_stall, flush, exc_ack,
        input ex_ready, mem_valid, mem_regwen, mem_memren, mem_memwen, branch_taken,
              mem_result, mem_storedata, mem_btarget, epc, mem_wsel, exc_req, ovf_count
    );
endinterface

// File: rtl/ex_mem_trap.sv
// ex_mem_trap: overflow trap FSM with epc capture and saturating trap count
// ports: CLK, nRST; ovf_hit (qualified overflow), exc_ack, ex_pc in; trap, squash, exc_req, epc, ovf_count out
module ex_mem_trap
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ovf_hit,
    input  logic       exc_ack,
    input  word_t      ex_pc,
    output logic       trap,
    output logic       squash,
    output logic       exc_req,
    output word_t      epc,
    output logic [7:0] ovf_count
);
    trapstate_t state, next_state;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state <= IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state;
        trap = 1'b0;
        if (state == IDLE) begin
            trap = ovf_hit;
            next_state = ovf_hit ? TRAP : IDLE;
        end else next_state = exc_ack ? IDLE : TRAP;
    end
    assign squash = state == TRAP;
    assign exc_req = squash;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            epc <= '0;
            ovf_count <= '0;
        end else if (trap) begin
            epc <= ex_pc;
            ovf_count <= ovf_count + {7'd0, ovf_count != 8'hff};
        end
endmodule

// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register with stall, flush and signed-overflow trap squashing
// ports: CLK, nRST; emif (ex_mem_if.latch) carries ALU/EX inputs, stall/flush/ack and registered MEM outputs
module ex_mem_latch
    import cpu_types_pkg::*;
#(
    parameter bit TRAP_EN = 1'b1
) (
    input logic CLK,
    input logic nRST,
    ex_mem_if.latch emif
);
    logic ovf_hit, trap, squash, keep, unused;
    assign unused = emif.negative;
    assign emif.ex_ready = !emif.mem_stall;
    assign ovf_hit = TRAP_EN && emif.ex_valid && emif.ex_ovfchk && emif.overflow && !emif.flush && !emif.mem_stall;
    // a trapping instruction still occupies the slot but loses all side effects
    assign keep = !(emif.flush || squash || trap);
    ex_mem_trap u_trap (
        .CLK(CLK), .nRST(nRST), .ovf_hit(ovf_hit), .exc_ack(emif.exc_ack), .ex_pc(emif.ex_pc),
        .trap(trap), .squash(squash), .exc_req(emif.exc_req), .epc(emif.epc), .ovf_count(emif.ovf_count)
    );
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            emif.mem_valid <= 1'b0;
            emif.mem_regwen <= 1'b0;
            emif.mem_memren <= 1'b0;
            emif.mem_memwen <= 1'b0;
            emif.branch_taken <= 1'b0;
            emif.mem_result <= '0;
            emif.mem_storedata <= '0;
            emif.mem_btarget <= '0;
            emif.mem_wsel <= '0;
        end else if (!emif.mem_stall) begin
            emif.mem_valid <= !(emif.flush || squash) && emif.ex_valid;
            emif.mem_regwen <= keep && emif.ex_regwen;
            emif.mem_memren <= keep && emif.ex_memren;
            emif.mem_memwen <= keep && emif.ex_memwen;
            emif.branch_taken <= keep && emif.ex_valid && ((emif.ex_beq && emif.zero) || (emif.ex_bne && !emif.zero));
            emif.mem_result <= emif.outputPort;
            emif.mem_storedata <= emif.ex_storedata;
            emif.mem_btarget <= emif.ex_btarget;
            emif.mem_wsel <= emif.ex_wsel;
        end
endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch: scoreboard bench for the EX/MEM latch, stall, branch and overflow trap behaviour
module tb_ex_mem_latch;
    typedef struct packed {
        logic valid, regwen, memren, memwen, beq, bne, ovfchk, ovf, zero, stall, flush, ack;
        logic [31:0] res, pc, sd, bt;
        logic [4:0] wsel;
    } stim_t;
    typedef struct packed {
        logic valid, regwen, memren, memwen, bt, excreq;
        logic [31:0] res, sd, btgt, epc;
        logic [4:0] wsel;
        logic [7:0] cnt;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t m;
    logic m_trap;
    exp_t sb[$];
    stim_t s;

    always #5 CLK = ~CLK;

    ex_mem_if ifc();
    ex_mem_latch #(.TRAP_EN(1'b1)) dut (.CLK(CLK), .nRST(nRST), .emif(ifc.latch));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t r;
        r = '0;
        return r;
    endfunction

    task automatic apply(input stim_t x);
        ifc.ex_valid = x.valid; ifc.ex_regwen = x.regwen; ifc.ex_memren = x.memren;
        ifc.ex_memwen = x.memwen; ifc.ex_beq = x.beq; ifc.ex_bne = x.bne;
        ifc.ex_ovfchk = x.ovfchk; ifc.overflow = x.ovf; ifc.zero = x.zero;
        ifc.negative = x.res[31]; ifc.mem_stall = x.stall; ifc.flush = x.flush;
        ifc.exc_ack = x.ack; ifc.outputPort = x.res; ifc.ex_pc = x.pc;
        ifc.ex_storedata = x.sd; ifc.ex_btarget = x.bt; ifc.ex_wsel = x.wsel;
    endtask

    task automatic compare(input exp_t e);
        check("mem_valid", ifc.mem_valid, e.valid);
        check("mem_regwen", ifc.mem_regwen, e.regwen);
        check("mem_memren", ifc.mem_memren, e.memren);
        check("mem_memwen", ifc.mem_memwen, e.memwen);
        check("branch_taken", ifc.branch_taken, e.bt);
        check("exc_req", ifc.exc_req, e.excreq);
        check("epc", ifc.epc, e.epc);
        check("ovf_count", ifc.ovf_count, e.cnt);
        if (e.valid) begin
            check("mem_result", ifc.mem_result, e.res);
            check("mem_storedata", ifc.mem_storedata, e.sd);
            check("mem_btarget", ifc.mem_btarget, e.btgt);
            check("mem_wsel", ifc.mem_wsel, e.wsel);
        end
    endtask

    task automatic step(input stim_t x);
        logic hit;
        @(negedge CLK);
        apply(x);
        #1 check("ex_ready", ifc.ex_ready, !x.stall);
        hit = x.valid && x.ovfchk && x.ovf && !x.flush && !x.stall && !m_trap;
        if (!x.stall) begin
            if (x.flush || m_trap) begin
                m.valid = 0; m.regwen = 0; m.memren = 0; m.memwen = 0; m.bt = 0;
            end else begin
                m.valid = x.valid;
                m.regwen = x.regwen && !hit;
                m.memren = x.memren && !hit;
                m.memwen = x.memwen && !hit;
                m.bt = !hit && x.valid && ((x.beq && x.zero) || (x.bne && !x.zero));
                m.res = x.res; m.sd = x.sd; m.btgt = x.bt; m.wsel = x.wsel;
            end
            if (hit) begin
                m.epc = x.pc;
                if (m.cnt != 8'hff) m.cnt = m.cnt + 8'd1;
            end
        end
        m_trap = m_trap ? !x.ack : hit;
        m.excreq = m_trap;
        sb.push_back(m);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) check("scoreboard_empty", 0, 1);
        else compare(sb.pop_front());
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_valid", ifc.mem_valid, 0);
        check("rst_mem_regwen", ifc.mem_regwen, 0);
        check("rst_mem_memren", ifc.mem_memren, 0);
        check("rst_mem_memwen", ifc.mem_memwen, 0);
        check("rst_branch_taken", ifc.branch_taken, 0);
        check("rst_mem_result", ifc.mem_result, 0);
        check("rst_mem_wsel", ifc.mem_wsel, 0);
        check("rst_epc", ifc.epc, 0);
        check("rst_exc_req", ifc.exc_req, 0);
        check("rst_ovf_count", ifc.ovf_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m = '0;
        m_trap = 0;
        apply(idle());
        #2 check_reset_outputs();
        @(negedge CLK) nRST = 1'b1;

        s = idle(); s.valid = 1; s.res = 32'h10; s.wsel = 5; s.regwen = 1;
        step(s);
        check("normal_result", ifc.mem_result, 32'h10);

        s = idle(); s.valid = 1; s.res = 32'h20; s.wsel = 7; s.memwen = 1; s.sd = 32'hdead; s.stall = 1;
        step(s);
        s.flush = 1; step(s);
        s.flush = 0; s.ovfchk = 1; s.ovf = 1; s.pc = 32'h80; step(s);
        s.ovfchk = 0; s.ovf = 0; s.stall = 0; step(s);

        s = idle(); s.valid = 1; s.beq = 1; s.zero = 1; s.bt = 32'h40; step(s);
        s = idle(); s.valid = 1; s.bne = 1; s.zero = 1; s.bt = 32'h44; step(s);
        s.zero = 0; step(s);
        s.stall = 1; step(s);
        s = idle(); s.beq = 1; s.zero = 1; step(s);
        s = idle(); s.valid = 1; s.memren = 1; s.res = 32'h1234; s.wsel = 9; step(s);

        s = idle(); s.valid = 1; s.ovfchk = 1; s.ovf = 0; s.regwen = 1; s.res = 32'h7; step(s);
        s = idle(); s.valid = 1; s.ovf = 1; s.regwen = 1; s.res = 32'h8; step(s);
        s = idle(); s.ack = 1; step(s);

        s = idle(); s.valid = 1; s.ovfchk = 1; s.ovf = 1; s.pc = 32'h100; s.regwen = 1; s.beq = 1; s.zero = 1;
        step(s);
        check("trap_epc", ifc.epc, 32'h100);
        s.pc = 32'h200; step(s);
        s = idle(); s.valid = 1; s.regwen = 1; s.res = 32'h55; step(s);
        s.stall = 1; step(s);
        s.stall = 0; s.ack = 1; s.res = 32'h66; step(s);
        s = idle(); s.valid = 1; s.regwen = 1; s.res = 32'h77; s.wsel = 3; step(s);

        s = idle(); s.valid = 1; s.ovfchk = 1; s.ovf = 1; s.flush = 1; s.regwen = 1; s.pc = 32'h300; step(s);
        s = idle(); s.valid = 1; s.regwen = 1; s.flush = 1; step(s);

        s = idle(); s.valid = 1; s.ovfchk = 1; s.ovf = 1; s.pc = 32'h400; step(s);
        s = idle(); s.valid = 1; s.stall = 1; s.res = 32'h99; step(s);
        @(negedge CLK);
        nRST = 1'b0;
        #1 check_reset_outputs();
        m = '0;
        m_trap = 0;
        sb.delete();
        apply(idle());
        @(negedge CLK) nRST = 1'b1;
        s = idle(); s.valid = 1; s.regwen = 1; s.res = 32'hab; s.wsel = 1; step(s);

        for (int i = 0; i < 257; i++) begin
            s = idle(); s.valid = 1; s.ovfchk = 1; s.ovf = 1; s.pc = i; step(s);
            s = idle(); s.ack = 1; step(s);
        end
        check("ovf_saturate", ifc.ovf_count, 8'hff);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
